adder_share_sched: RTL and testbench
====================================

Name: adder_share_sched

Overview:
- Scheduler that time-shares one external 8-bit two-stage pipelined LCA adder among P_NUM_REQ requesters.
- Arbitrates round-robin and drives the adder operands.
- Holds the operands stable for P_HOLD cycles, so both the low half and the registered high half settle on the same operand set.
- Captures the sum and carry vector, then returns them with the requester ID over a valid/ready response channel.

Parameters:
- P_NUM_REQ, 4, number of requesters (2..8)
- P_DATA_WIDTH, 8, operand and sum width
- P_HOLD, 2, cycles operands are held on the adder before sampling (>=2)
- P_ID_W, 2, width of o_rsp_id (= clog2(P_NUM_REQ))

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_req_valid  in  P_NUM_REQ  per-requester request valid
- o_req_ready  out  P_NUM_REQ  one-hot accept (combinational)
- i_req_a  in  P_NUM_REQ*P_DATA_WIDTH  packed operand A; requester k at [k*W +: W]
- i_req_b  in  P_NUM_REQ*P_DATA_WIDTH  packed operand B
- i_req_cin  in  P_NUM_REQ  per-requester carry-in
- o_add_a  out  P_DATA_WIDTH  adder operand A (registered)
- o_add_b  out  P_DATA_WIDTH  adder operand B (registered)
- o_add_cin  out  1  adder carry-in (registered)
- i_add_sum  in  P_DATA_WIDTH  adder sum
- i_add_cout  in  P_DATA_WIDTH  adder per-bit carry vector
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accept
- o_rsp_id  out  P_ID_W  index of the served requester
- o_rsp_sum  out  P_DATA_WIDTH  captured sum
- o_rsp_cout  out  1  captured final carry, i_add_cout[W-1]
- o_busy  out  1  high in any state other than IDLE
- o_op_cnt  out  16  completed-operation count (optional feature)

Behaviour:
- Reset: all outputs are 0, state is IDLE, round-robin pointer = P_NUM_REQ-1 (requester 0 has priority first), hold counter = 0. Reset is asynchronous and takes effect mid-operation: any in-flight operation is dropped and no response is issued.

FSM states:
- IDLE:
  - o_req_ready = one-hot grant of the first valid requester, searching from pointer+1 with wrap-around.
  - The grant is zero when no request is valid.
  - On grant k: latch A/B/cin of k into o_add_*, latch ID k, set pointer = k, counter = 0, go to HOLD.
- HOLD:
  - o_add_* is stable and o_req_ready = 0.
  - Counter increments each cycle.
  - In the cycle counter == P_HOLD-1: register i_add_sum into o_rsp_sum and i_add_cout[W-1] into o_rsp_cout, set o_rsp_valid = 1, go to RESP.
- RESP:
  - o_rsp_valid is held with ID, sum and cout stable until i_rsp_ready = 1.
  - On the accept cycle: clear o_rsp_valid, go to IDLE.
  - No new grant in the accept cycle.

Timing and ordering:
- Latency: request accepted at edge T; operands on the adder from T+1 to T+P_HOLD; o_rsp_valid rises at T+P_HOLD.
- Minimum issue interval is P_HOLD+2 cycles.
- o_add_* retain their last values in IDLE and RESP; they update only on a grant.
- Simultaneous requests: exactly one grant per IDLE cycle, round-robin fair. A requester that was just served has lowest priority next.
- Requests withdrawn before a grant are simply not served. Requesters must keep valid and data stable until ready.
- Arithmetic: no width extension. Sum wraps modulo 2^W; carry out is reported only via o_rsp_cout.

Optional Feature:
- Macro: ADDER_SHARE_STATS_EN
- Defined: o_op_cnt increments on each response handshake (o_rsp_valid & i_rsp_ready), saturates at 16'hFFFF, and resets to 0.
- Undefined: no counter logic is built and o_op_cnt is tied to 0.

Test Plan:
- Single request: req1 with A=8'h3C, B=8'h0F, cin=0, i_rsp_ready=1 -> o_rsp_valid P_HOLD cycles after accept, id=1, sum=8'h4B, cout=0.
- Carry: req0 with A=8'hFF, B=8'h01, cin=1 -> sum=8'h01, cout=1, high half correct (checks the hold window).
- All four requesters valid continuously -> grant order 0,1,2,3,0; each response id matches its own operands.
- Backpressure: i_rsp_ready=0 for 5 cycles -> o_rsp_valid, id and sum stay stable; no new o_req_ready until the accept.
- Reset mid-HOLD: assert i_rst while counter=1 -> all outputs 0 immediately, no response issued, next grant goes to requester 0.
- With ADDER_SHARE_STATS_EN: 3 completed ops -> o_op_cnt=3. Without it -> o_op_cnt=0.

Source files
------------

// File: rtl/adder_share_sched.sv
// adder_share_sched
// Purpose : time-shares one external two-stage pipelined adder among
//           P_NUM_REQ requesters. Arbitration is round-robin. Operands are
//           held for P_HOLD cycles so that the registered high half settles,
//           and the result is returned with the requester ID.
// Latency : a grant at edge T drives operands from T. o_rsp_valid rises at
//           edge T+P_HOLD. The minimum issue interval is P_HOLD+2 cycles.
// Backpr. : the response is held stable until i_rsp_ready. While a response
//           is pending or a hold is in progress, no new request is accepted.
// Ports   : i_clk/i_rst           clock, asynchronous active-high reset
//           i_req_* / o_req_ready per-requester operands, valid, one-hot accept
//           o_add_* / i_add_*     external adder operands and results
//           o_rsp_*/i_rsp_ready   response channel (id, sum, final carry)
//           o_busy, o_op_cnt      status; completed-operation count
// Macro   : ADDER_SHARE_STATS_EN  builds the saturating o_op_cnt counter.
//           Without it, o_op_cnt is tied to 0.

module adder_share_sched #(
  parameter int P_NUM_REQ    = 4,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_HOLD       = 2,
  parameter int P_ID_W       = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [P_NUM_REQ-1:0]           i_req_valid,
  output logic [P_NUM_REQ-1:0]           o_req_ready,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_a,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_b,
  input  logic [P_NUM_REQ-1:0]           i_req_cin,
  output logic [P_DATA_WIDTH-1:0]        o_add_a,
  output logic [P_DATA_WIDTH-1:0]        o_add_b,
  output logic                           o_add_cin,
  input  logic [P_DATA_WIDTH-1:0]        i_add_sum,
  input  logic [P_DATA_WIDTH-1:0]        i_add_cout,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [P_ID_W-1:0]              o_rsp_id,
  output logic [P_DATA_WIDTH-1:0]        o_rsp_sum,
  output logic                           o_rsp_cout,
  output logic                           o_busy,
  output logic [15:0]                    o_op_cnt
);

  localparam int                  LP_CNT_W    = $clog2(P_HOLD);
  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(P_HOLD - 1);
  localparam logic [P_ID_W-1:0]   LP_PTR_RST  = P_ID_W'(P_NUM_REQ - 1);
  localparam logic [P_ID_W:0]     LP_NUM_EXT  = (P_ID_W + 1)'(P_NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [P_ID_W-1:0]       r_ptr;
  logic [LP_CNT_W-1:0]     r_cnt;
  logic [P_DATA_WIDTH-1:0] r_add_a;
  logic [P_DATA_WIDTH-1:0] r_add_b;
  logic                    r_add_cin;
  logic [P_ID_W-1:0]       r_id;
  logic                    r_rsp_vld;
  logic [P_DATA_WIDTH-1:0] r_rsp_sum;
  logic                    r_rsp_cout;

  logic [P_NUM_REQ-1:0]    w_grant;
  logic [P_ID_W-1:0]       w_grant_idx;
  logic                    w_found;
  logic [P_ID_W:0]         w_cand_ext;
  logic [P_ID_W-1:0]       w_cand;
  logic [P_DATA_WIDTH-1:0] w_sel_a;
  logic [P_DATA_WIDTH-1:0] w_sel_b;
  logic                    w_sel_cin;

  // Only the final carry bit of the adder's carry vector is reported.
  logic w_unused;
  assign w_unused = ^{1'b0, i_add_cout[P_DATA_WIDTH-2:0]};

  // Round-robin search. It starts one past the last served requester and
  // wraps around, so the requester that was just served has the lowest
  // priority. The candidate index is formed one bit wider so that the
  // wrap-around works for any P_NUM_REQ, including non-powers of two.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_cand_ext  = '0;
    w_cand      = '0;
    for (int off = 1; off <= P_NUM_REQ; off++) begin
      w_cand_ext = {1'b0, r_ptr} + (P_ID_W + 1)'(off);
      if (w_cand_ext >= LP_NUM_EXT) begin
        w_cand_ext = w_cand_ext - LP_NUM_EXT;
      end
      w_cand = w_cand_ext[P_ID_W-1:0];
      if (!w_found && i_req_valid[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    if (w_found) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  // Operand mux, driven by the one-hot grant.
  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_a   = i_req_a[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        w_sel_b   = i_req_b[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        w_sel_cin = i_req_cin[k];
      end
    end
  end

  // Accept only in IDLE. The term on i_rst keeps ready low while reset is
  // asserted, so no request is accepted during reset.
  assign o_req_ready = (r_state == S_IDLE && !i_rst) ? w_grant : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= LP_PTR_RST;
      r_cnt      <= '0;
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_add_cin  <= 1'b0;
      r_id       <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_sum  <= '0;
      r_rsp_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_add_a   <= w_sel_a;
            r_add_b   <= w_sel_b;
            r_add_cin <= w_sel_cin;
            r_id      <= w_grant_idx;
            r_ptr     <= w_grant_idx;
            r_cnt     <= '0;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_cnt <= r_cnt + 1'b1;
          // The high half of the adder is registered. After P_HOLD cycles,
          // both halves reflect the held operand set.
          if (r_cnt == LP_CNT_LAST) begin
            r_rsp_sum  <= i_add_sum;
            r_rsp_cout <= i_add_cout[P_DATA_WIDTH-1];
            r_rsp_vld  <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          // No grant in the accept cycle. Arbitration resumes from IDLE.
          if (i_rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_add_cin   = r_add_cin;
  assign o_rsp_valid = r_rsp_vld;
  assign o_rsp_id    = r_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;
  assign o_busy      = (r_state != S_IDLE);

`ifdef ADDER_SHARE_STATS_EN
  logic [15:0] r_op_cnt;

  // Counts response handshakes. The count saturates at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op_cnt <= '0;
    end else if (r_rsp_vld && i_rsp_ready && (r_op_cnt != 16'hFFFF)) begin
      r_op_cnt <= r_op_cnt + 16'd1;
    end
  end

  assign o_op_cnt = r_op_cnt;
`else
  assign o_op_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_share_sched.sv
// tb_adder_share_sched
// Purpose : directed bench for adder_share_sched. It includes a model of a
//           two-stage adder whose low half is combinational and whose high
//           half is registered.
// Latency : expectations assume P_HOLD = 2 (the response two edges after grant).

module tb_adder_share_sched;

  localparam int N = 4;
  localparam int W = 8;
`ifdef ADDER_SHARE_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic [N-1:0]   i_req_valid;
  logic [N-1:0]   o_req_ready;
  logic [N*W-1:0] i_req_a;
  logic [N*W-1:0] i_req_b;
  logic [N-1:0]   i_req_cin;
  logic [W-1:0]   o_add_a;
  logic [W-1:0]   o_add_b;
  logic           o_add_cin;
  logic [W-1:0]   i_add_sum;
  logic [W-1:0]   i_add_cout;
  logic           o_rsp_valid;
  logic           i_rsp_ready;
  logic [1:0]     o_rsp_id;
  logic [W-1:0]   o_rsp_sum;
  logic           o_rsp_cout;
  logic           o_busy;
  logic [15:0]    o_op_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rr_sum  [4] = '{8'hF1, 8'h03, 8'h38, 8'h05};
  logic       rr_cout [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 i_clk = ~i_clk;

  adder_share_sched #(
    .P_NUM_REQ(N), .P_DATA_WIDTH(W), .P_HOLD(2), .P_ID_W(2)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_cin(i_req_cin),
    .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_cin(o_add_cin),
    .i_add_sum(i_add_sum), .i_add_cout(i_add_cout),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_id(o_rsp_id), .o_rsp_sum(o_rsp_sum), .o_rsp_cout(o_rsp_cout),
    .o_busy(o_busy), .o_op_cnt(o_op_cnt)
  );

  // External adder model: ripple sum with per-bit carry vector. The high
  // half is seen one clock late.
  logic [W-1:0]   m_sum;
  logic [W-1:0]   m_cvec;
  logic [W/2-1:0] m_hi_sum_q;
  logic [W/2-1:0] m_hi_c_q;

  always_comb begin
    logic c;
    c      = o_add_cin;
    m_sum  = '0;
    m_cvec = '0;
    for (int i = 0; i < W; i++) begin
      m_sum[i]  = o_add_a[i] ^ o_add_b[i] ^ c;
      c         = (o_add_a[i] & o_add_b[i]) | (c & (o_add_a[i] ^ o_add_b[i]));
      m_cvec[i] = c;
    end
  end

  always @(posedge i_clk) begin
    m_hi_sum_q <= m_sum[W-1:W/2];
    m_hi_c_q   <= m_cvec[W-1:W/2];
  end

  assign i_add_sum  = {m_hi_sum_q, m_sum[W/2-1:0]};
  assign i_add_cout = {m_hi_c_q, m_cvec[W/2-1:0]};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic c);
    i_req_a[k*W +: W] = a;
    i_req_b[k*W +: W] = b;
    i_req_cin[k]      = c;
    i_req_valid[k]    = 1'b1;
  endtask

  // Waits for o_rsp_valid and returns the number of edges waited.
  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_rsp_valid) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // A single request, served with i_rsp_ready already high.
  task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input string tag);
    int n;
    i_req_valid = '0;
    set_req(k, a, b, c);
    #1;
    n = 0;
    while (!o_req_ready[k] && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    check_val({tag, "_grant"}, 32'(o_req_ready), 32'(1 << k));
    @(posedge i_clk); #1;                     // grant edge
    i_req_valid = '0;
    check_val({tag, "_ops"}, {o_busy, o_add_cin, o_add_a, o_add_b}, {1'b1, c, a, b});
    wait_rsp(tag, n);
    check_val({tag, "_lat"}, n, 2);
    check_val({tag, "_id"}, o_rsp_id, k);
    check_val({tag, "_sum"}, o_rsp_sum, es);
    check_val({tag, "_cout"}, o_rsp_cout, ec);
    @(posedge i_clk); #1;                     // accept edge
    check_val({tag, "_done"}, {o_rsp_valid, o_busy}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    i_req_valid = '0;
    i_req_a     = '0;
    i_req_b     = '0;
    i_req_cin   = '0;
    i_rsp_ready = 1'b1;

    // Reset state. A pending request must not be accepted during reset.
    repeat (2) @(posedge i_clk);
    #1;
    i_req_valid = 4'b0001;
    #1;
    check_val("rst_ready", o_req_ready, 0);
    check_val("rst_outs", {o_busy, o_rsp_valid, o_add_a, o_add_b, o_add_cin, o_rsp_sum, o_rsp_id, o_rsp_cout}, 0);
    check_val("rst_opcnt", o_op_cnt, 0);
    i_req_valid = '0;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check_val("idle_busy", o_busy, 0);

    // All four requesters valid: the grant order is 0,1,2,3,0.
    set_req(0, 8'h11, 8'hE0, 1'b0);
    set_req(1, 8'h22, 8'hE0, 1'b1);
    set_req(2, 8'h33, 8'h05, 1'b0);
    set_req(3, 8'h44, 8'hC0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_rsp("rr", n);
      check_val("rr_id", o_rsp_id, i % 4);
      check_val("rr_sum", o_rsp_sum, rr_sum[i % 4]);
      check_val("rr_cout", o_rsp_cout, rr_cout[i % 4]);
      check_val("rr_noready", o_req_ready, 0);
      if (i == 3) check_val("opcnt3", o_op_cnt, (STATS_ON != 0) ? 3 : 0);
      if (i == 4) i_req_valid = '0;
      @(posedge i_clk); #1;
    end

    do_op(1, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "single");
    do_op(0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, "carry");

    // Backpressure: the response must stay frozen and nothing is accepted.
    i_rsp_ready = 1'b0;
    i_req_valid = '0;
    set_req(2, 8'h5A, 8'h25, 1'b0);
    set_req(3, 8'h80, 8'h80, 1'b0);
    wait_rsp("bp", n);
    check_val("bp_id", o_rsp_id, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      check_val("bp_hold", {o_rsp_valid, o_rsp_id, o_rsp_sum, o_req_ready}, {1'b1, 2'd2, 8'h7F, 4'b0000});
    end
    i_req_valid[2] = 1'b0;
    i_rsp_ready    = 1'b1;
    @(posedge i_clk); #1;                     // accept edge, no grant here
    check_val("bp_accept", {o_rsp_valid, o_busy, o_req_ready}, {1'b0, 1'b0, 4'b1000});
    wait_rsp("bp2", n);
    check_val("bp2_rsp", {o_rsp_id, o_rsp_sum, o_rsp_cout}, {2'd3, 8'h00, 1'b1});
    i_req_valid = '0;
    @(posedge i_clk); #1;
    check_val("opcnt9", o_op_cnt, (STATS_ON != 0) ? 9 : 0);

    // Reset while the hold counter is 1.
    set_req(2, 8'h5A, 8'h25, 1'b0);
    #1;
    check_val("mh_grant", o_req_ready, 4'b0100);
    @(posedge i_clk); #1;                     // grant, counter 0
    i_req_valid = '0;
    @(posedge i_clk); #1;                     // counter 1
    check_val("mh_pre", {o_busy, o_rsp_valid, o_add_a}, {1'b1, 1'b0, 8'h5A});
    i_rst = 1'b1;
    #1;
    check_val("mh_rst", {o_busy, o_rsp_valid, o_add_a, o_add_b, o_add_cin, o_rsp_sum, o_rsp_id, o_rsp_cout}, 0);
    check_val("mh_opcnt", o_op_cnt, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge i_clk); #1;
      seen = seen | o_rsp_valid;
    end
    check_val("mh_norsp", seen, 0);
    set_req(0, 8'h0A, 8'h05, 1'b0);
    set_req(3, 8'h01, 8'h01, 1'b0);
    #1;
    check_val("mh_next", o_req_ready, 4'b0001);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    wait_rsp("mh", n);
    check_val("mh_rsp", {o_rsp_id, o_rsp_sum, o_rsp_cout}, {2'd0, 8'h0F, 1'b0});
    @(posedge i_clk); #1;
    check_val("mh_opcnt1", o_op_cnt, (STATS_ON != 0) ? 1 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
